// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with parity, 1/2 stop bits, glitch rejection,
// error flags and a ready/valid output with overrun detection.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_Rx_serial,
   input  logic                 i_RX_ready,
   output logic [DATA_BITS-1:0] o_RX,
   output logic                 o_RX_DV,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overrun,
   output logic                 o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK_WAIT} state_t;

   state_t state, state_nx;
   logic rx_m, rx_s, ferr, par_q, perr, tick, load;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   logic [DATA_BITS-1:0] data_q;

   assign tick = cnt == LAST;
   assign perr = (PARITY_MODE != 0) && (^data_q ^ par_q ^ (PARITY_MODE == 2));
   assign load = state == DELIVER && (!o_RX_DV || i_RX_ready);
   assign o_busy = state != IDLE;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) {rx_m, rx_s} <= 2'b11;
      else {rx_m, rx_s} <= {i_Rx_serial, rx_m};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (!rx_s) state_nx = START;
         START:      if (cnt == MID) state_nx = rx_s ? IDLE : DATA;
         DATA:       if (tick && idx == 4'(DATA_BITS - 1)) state_nx = PARITY_MODE != 0 ? PARITY : STOP;
         PARITY:     if (tick) state_nx = STOP;
         STOP:       if (tick && idx == 4'(STOP_BITS - 1)) state_nx = DELIVER;
         DELIVER:    state_nx = ferr ? BREAK_WAIT : IDLE;
         BREAK_WAIT: if (rx_s) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // counter restarts on every transition, so DATA ticks land one bit period after mid-start
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         data_q <= '0;
         par_q  <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state || tick) ? '0 : cnt + 1'b1;
         idx   <= state_nx != state ? '0 : (tick && (state == DATA || state == STOP)) ? idx + 1'b1 : idx;
         if (state == DATA && tick) data_q <= {rx_s, data_q[DATA_BITS-1:1]};
         if (state == PARITY && tick) par_q <= rx_s;
         if (state == START) ferr <= 1'b0;
         else if (state == STOP && tick && !rx_s) ferr <= 1'b1;
      end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         o_RX         <= '0;
         o_RX_DV      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= state == DELIVER && o_RX_DV && !i_RX_ready;
         if (load) begin
            o_RX         <= data_q;
            o_frame_err  <= ferr;
            o_parity_err <= perr;
            o_RX_DV      <= 1'b1;
         end else if (o_RX_DV && i_RX_ready) o_RX_DV <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench driving an 8N1 receiver and two 7-bit, 2-stop parity receivers.
module tb_uart_rx_param;
   localparam int CPB = 16;
   localparam int MID = (CPB - 1) / 2;

   logic clk = 1'b0;
   logic rst;
   logic rx_line [3];
   logic rdy [3];
   logic [7:0] rx_a;
   logic [6:0] rx_p, rx_o;
   logic dv [3], fe [3], pe [3], ov [3], busy [3];
   logic [8:0] d [3];
   int checks = 0, failures = 0;
   logic [10:0] exp_q [3][$];
   int ov_cnt [3];
   logic pdv [3], pacc [3];
   int base;

   always #5 clk = ~clk;

   always_comb begin
      d[0] = {1'b0, rx_a};
      d[1] = {2'b0, rx_p};
      d[2] = {2'b0, rx_o};
   end

   uart_rx_param #(.CLKS_PER_BIT(CPB)) u_a (
      .i_clk(clk), .i_rst(rst), .i_Rx_serial(rx_line[0]), .i_RX_ready(rdy[0]),
      .o_RX(rx_a), .o_RX_DV(dv[0]), .o_frame_err(fe[0]), .o_parity_err(pe[0]),
      .o_overrun(ov[0]), .o_busy(busy[0]));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_p (
      .i_clk(clk), .i_rst(rst), .i_Rx_serial(rx_line[1]), .i_RX_ready(rdy[1]),
      .o_RX(rx_p), .o_RX_DV(dv[1]), .o_frame_err(fe[1]), .o_parity_err(pe[1]),
      .o_overrun(ov[1]), .o_busy(busy[1]));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_o (
      .i_clk(clk), .i_rst(rst), .i_Rx_serial(rx_line[2]), .i_RX_ready(rdy[2]),
      .o_RX(rx_o), .o_RX_DV(dv[2]), .o_frame_err(fe[2]), .o_parity_err(pe[2]),
      .o_overrun(ov[2]), .o_busy(busy[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx_line[s] = bits[i];
         tick(CPB);
      end
   endtask

   task automatic ack(input int s);
      rdy[s] = 1'b1;
      tick(1);
      rdy[s] = 1'b0;
   endtask

   function automatic logic [15:0] f8(input logic [7:0] v, input logic stop);
      return {6'b0, stop, v, 1'b0};
   endfunction

   function automatic logic [15:0] f7(input logic [6:0] v, input logic par);
      return {5'b0, 2'b11, par, v, 1'b0};
   endfunction

   function automatic logic [10:0] w(input logic p, input logic f, input logic [8:0] v);
      return {p, f, v};
   endfunction

   // a word is new when DV rises or stays high right after an accepting cycle
   task automatic monitor();
      for (int k = 0; k < 3; k++) begin
         if (dv[k] && (!pdv[k] || pacc[k])) begin
            if (exp_q[k].size() == 0) check($sformatf("unexpected_dv%0d", k), dv[k], 0);
            else check($sformatf("word%0d", k), {pe[k], fe[k], d[k]}, exp_q[k].pop_front());
         end
         if (ov[k]) ov_cnt[k]++;
         pdv[k] = dv[k];
         pacc[k] = dv[k] & rdy[k];
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rx_line[k] = 1'b1;
         rdy[k] = 1'b0;
         pdv[k] = 1'b0;
         pacc[k] = 1'b0;
         ov_cnt[k] = 0;
      end
      fork
         forever begin
            @(negedge clk);
            monitor();
         end
      join_none
      tick(3);
      check("reset_outputs", {d[0], dv[0], fe[0], pe[0], ov[0], busy[0]}, 0);
      rst = 1'b0;
      tick(CPB);

      exp_q[0].push_back(w(0, 0, 9'h32));
      send(0, f8(8'h32, 1'b1), 10);
      tick(10 * CPB);
      check("dv_hold", dv[0], 1);
      ack(0);
      check("dv_drop", dv[0], 0);

      rx_line[0] = 1'b0;
      tick(4);
      rx_line[0] = 1'b1;
      check("glitch_busy", busy[0], 1);
      tick(2 * CPB);
      check("glitch_idle", busy[0], 0);
      check("glitch_no_dv", dv[0], 0);
      exp_q[0].push_back(w(0, 0, 9'h5A));
      send(0, f8(8'h5A, 1'b1), 10);
      ack(0);

      exp_q[1].push_back(w(0, 0, 9'h25));
      send(1, f7(7'h25, 1'b1), 11);
      ack(1);
      exp_q[1].push_back(w(1, 0, 9'h25));
      send(1, f7(7'h25, 1'b0), 11);
      ack(1);
      exp_q[2].push_back(w(0, 0, 9'h25));
      send(2, f7(7'h25, 1'b0), 11);
      ack(2);
      exp_q[2].push_back(w(1, 0, 9'h25));
      send(2, f7(7'h25, 1'b1), 11);
      ack(2);

      exp_q[0].push_back(w(0, 1, 9'hA5));
      send(0, f8(8'hA5, 1'b0), 10);
      tick(2 * CPB);
      ack(0);
      tick(3 * CPB);
      check("break_no_dv", dv[0], 0);
      check("break_busy", busy[0], 1);
      rx_line[0] = 1'b1;
      tick(CPB);
      exp_q[0].push_back(w(0, 0, 9'h0F));
      send(0, f8(8'h0F, 1'b1), 10);
      ack(0);

      base = ov_cnt[0];
      exp_q[0].push_back(w(0, 0, 9'h11));
      send(0, f8(8'h11, 1'b1), 10);
      send(0, f8(8'h22, 1'b1), 10);
      check("overrun_pulse", ov_cnt[0] - base, 1);
      check("overrun_keep", d[0], 9'h11);
      ack(0);

      base = ov_cnt[0];
      exp_q[0].push_back(w(0, 0, 9'h11));
      exp_q[0].push_back(w(0, 0, 9'h22));
      send(0, f8(8'h11, 1'b1), 10);
      fork
         send(0, f8(8'h22, 1'b1), 10);
         begin
            tick(4 + MID + 9 * CPB);
            ack(0);
         end
      join
      check("reload_no_overrun", ov_cnt[0] - base, 0);
      check("reload_dv", dv[0], 1);
      check("reload_word", d[0], 9'h22);

      fork
         send(0, f8(8'hC3, 1'b1), 10);
         begin
            tick(5 * CPB + CPB / 2);
            #2 rst = 1'b1;
            #1 check("async_reset", {d[0], dv[0], fe[0], pe[0], ov[0], busy[0]}, 0);
         end
      join
      tick(1);
      rst = 1'b0;
      tick(CPB);
      exp_q[0].push_back(w(0, 0, 9'h3C));
      send(0, f8(8'h3C, 1'b1), 10);
      ack(0);

      tick(CPB);
      for (int k = 0; k < 3; k++) check($sformatf("queue_empty%0d", k), exp_q[k].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
